// File: rtl/eth_gt_link_supervisor.sv
// Link bring-up and health supervisor for 1..NUM_LANES 10G BASE-R GT lanes.
// Sequences the GT-wizard reset, qualifies per-lane block lock, retries lanes and counts drops.
module eth_gt_link_supervisor #(
  parameter int unsigned NUM_LANES     = 1,
  parameter int unsigned HOLD_CYCLES   = 1024,
  parameter int unsigned DONE_TIMEOUT  = 65536,
  parameter int unsigned LOCK_TIMEOUT  = 131072,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned MAX_RETRIES   = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_LANES-1:0]     lane_enable,
  input  logic [NUM_LANES-1:0]     clear_fail,
  input  logic [NUM_LANES-1:0]     gt_reset_tx_done,
  input  logic [NUM_LANES-1:0]     gt_reset_rx_done,
  input  logic [NUM_LANES-1:0]     rx_block_lock,
  output logic                     gt_reset_all,
  output logic [NUM_LANES-1:0]     gt_reset_rx_datapath,
  output logic [NUM_LANES-1:0]     link_up,
  output logic [NUM_LANES-1:0]     lane_failed,
  output logic                     all_up,
  output logic [8*NUM_LANES-1:0]   link_drop_count
);

  localparam int unsigned GMAX = (HOLD_CYCLES > DONE_TIMEOUT) ? HOLD_CYCLES : DONE_TIMEOUT;
  localparam int unsigned GW   = $clog2(GMAX + 1);
  localparam int unsigned LW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RW   = $clog2(MAX_RETRIES + 1);
  localparam int unsigned PW   = $clog2(RST_PULSE + 1);

  localparam logic [GW-1:0] HOLD_LAST  = GW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] DONE_LAST  = GW'(DONE_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_CNT = SW'(STABLE_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {G_HOLD, G_WAIT_DONE, G_RUN} g_state_t;
  typedef enum logic [2:0] {L_IDLE, L_WAIT_LOCK, L_RX_RST, L_UP, L_FAILED} l_state_t;

  logic [NUM_LANES-1:0] r_tx_meta, r_tx_sync;
  logic [NUM_LANES-1:0] r_rx_meta, r_rx_sync;
  logic [NUM_LANES-1:0] r_lock_meta, r_lock_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_meta   <= '0;
      r_tx_sync   <= '0;
      r_rx_meta   <= '0;
      r_rx_sync   <= '0;
      r_lock_meta <= '0;
      r_lock_sync <= '0;
    end else begin
      r_tx_meta   <= gt_reset_tx_done;
      r_tx_sync   <= r_tx_meta;
      r_rx_meta   <= gt_reset_rx_done;
      r_rx_sync   <= r_rx_meta;
      r_lock_meta <= rx_block_lock;
      r_lock_sync <= r_lock_meta;
    end
  end

  logic w_all_done;
  logic w_lanes_run;
  assign w_all_done = &(r_tx_sync & r_rx_sync);

  g_state_t        r_g_state, w_g_next;
  logic [GW-1:0]   r_g_cnt, w_g_cnt_next;
  logic            r_gt_reset_all;

  always_comb begin
    w_g_next     = r_g_state;
    w_g_cnt_next = r_g_cnt + 1'b1;
    unique case (r_g_state)
      G_HOLD: begin
        if (r_g_cnt == HOLD_LAST) begin
          w_g_next     = G_WAIT_DONE;
          w_g_cnt_next = '0;
        end
      end
      G_WAIT_DONE: begin
        if (w_all_done) begin
          w_g_next     = G_RUN;
          w_g_cnt_next = '0;
        end else if (r_g_cnt == DONE_LAST) begin
          w_g_next     = G_HOLD;
          w_g_cnt_next = '0;
        end
      end
      G_RUN: begin
        w_g_cnt_next = '0;
        if (!w_all_done) w_g_next = G_HOLD;
      end
      default: begin
        w_g_next     = G_HOLD;
        w_g_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_g_state      <= G_HOLD;
      r_g_cnt        <= '0;
      r_gt_reset_all <= 1'b1;
    end else begin
      r_g_state      <= w_g_next;
      r_g_cnt        <= w_g_cnt_next;
      r_gt_reset_all <= (w_g_next == G_HOLD);
    end
  end

  assign gt_reset_all = r_gt_reset_all;
  // Lanes drop out in the same cycle the global FSM leaves RUN, not one later.
  assign w_lanes_run  = (r_g_state == G_RUN) && w_all_done;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    l_state_t      r_state, w_next;
    logic [LW-1:0] r_lcnt, w_lcnt_n;
    logic [SW-1:0] r_scnt, w_scnt_n;
    logic [RW-1:0] r_retry, w_retry_n;
    logic [PW-1:0] r_pcnt, w_pcnt_n;
    logic [7:0]    r_drops, w_drops_n;
    logic          r_link_up, r_rx_rst, r_failed;
    logic          w_lock;

    assign w_lock = r_lock_sync[i];

    always_comb begin
      w_next    = r_state;
      w_lcnt_n  = r_lcnt;
      w_scnt_n  = r_scnt;
      w_retry_n = r_retry;
      w_pcnt_n  = r_pcnt;
      w_drops_n = r_drops;
      if (!w_lanes_run || !lane_enable[i]) begin
        w_next   = L_IDLE;
        w_pcnt_n = '0;
      end else begin
        unique case (r_state)
          L_IDLE: begin
            w_next   = L_WAIT_LOCK;
            w_lcnt_n = '0;
            w_scnt_n = '0;
          end
          L_WAIT_LOCK: begin
            w_lcnt_n = r_lcnt + 1'b1;
            w_scnt_n = w_lock ? r_scnt + 1'b1 : '0;
            // Stable target is tested first so it wins a tie with the timeout.
            if (r_scnt == STABLE_CNT) begin
              w_next    = L_UP;
              w_retry_n = '0;
            end else if (r_lcnt == LOCK_LAST) begin
              w_next   = L_RX_RST;
              w_pcnt_n = '0;
              if (r_retry != RETRY_MAX) w_retry_n = r_retry + 1'b1;
            end
          end
          L_RX_RST: begin
            if (r_pcnt == PULSE_LAST) begin
              w_next   = (r_retry == RETRY_MAX) ? L_FAILED : L_WAIT_LOCK;
              w_lcnt_n = '0;
              w_scnt_n = '0;
            end else begin
              w_pcnt_n = r_pcnt + 1'b1;
            end
          end
          L_UP: begin
            if (!w_lock) begin
              w_next   = L_WAIT_LOCK;
              w_lcnt_n = '0;
              w_scnt_n = '0;
              if (r_drops != 8'hFF) w_drops_n = r_drops + 1'b1;
            end
          end
          L_FAILED: begin
            if (clear_fail[i]) begin
              w_next    = L_WAIT_LOCK;
              w_retry_n = '0;
              w_lcnt_n  = '0;
              w_scnt_n  = '0;
            end
          end
          default: w_next = L_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state   <= L_IDLE;
        r_lcnt    <= '0;
        r_scnt    <= '0;
        r_retry   <= '0;
        r_pcnt    <= '0;
        r_drops   <= '0;
        r_link_up <= 1'b0;
        r_rx_rst  <= 1'b0;
        r_failed  <= 1'b0;
      end else begin
        r_state   <= w_next;
        r_lcnt    <= w_lcnt_n;
        r_scnt    <= w_scnt_n;
        r_retry   <= w_retry_n;
        r_pcnt    <= w_pcnt_n;
        r_drops   <= w_drops_n;
        r_link_up <= (r_state == L_UP) && (w_next == L_UP);
        r_rx_rst  <= (w_next == L_RX_RST);
        r_failed  <= (w_next == L_FAILED);
      end
    end

    assign link_up[i]              = r_link_up;
    assign gt_reset_rx_datapath[i] = r_rx_rst;
    assign lane_failed[i]          = r_failed;
    assign link_drop_count[8*i +: 8] = r_drops;
  end

  logic r_all_up;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_all_up <= 1'b0;
    else         r_all_up <= (|lane_enable) && (&(link_up | ~lane_enable));
  end

  assign all_up = r_all_up;

endmodule
